// File: rtl/uart_tx_ctrl_if.sv
// Handshake bundle between the byte source and the UART TX control stage.
//   P_DATA     : parallel payload, LSB is sent first
//   Data_Valid : payload strobe, only taken when the controller can accept
//   PAR_EN     : 1 inserts a parity bit after the data bits
//   PAR_TYP    : 0 even parity, 1 odd parity
//   mux_sel    : frame-bit select to the TX mux (000 start, 001 data, 010 parity,
//                011 stop, 101 idle)
//   ser_data   : current serial data bit
//   par_bit    : parity of the latched byte
//   busy       : frame in progress
// The byte source uses the master modport and the controller uses the slave modport.
interface uart_tx_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [2:0]            mux_sel;
  logic                  ser_data;
  logic                  par_bit;
  logic                  busy;

  modport master (
    output P_DATA,
    output Data_Valid,
    output PAR_EN,
    output PAR_TYP,
    input  mux_sel,
    input  ser_data,
    input  par_bit,
    input  busy
  );

  modport slave (
    input  P_DATA,
    input  Data_Valid,
    input  PAR_EN,
    input  PAR_TYP,
    output mux_sel,
    output ser_data,
    output par_bit,
    output busy
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmitter control and serialiser stage.
// Accepts a parallel byte with a valid strobe and sequences one frame:
// start bit, DATA_WIDTH data bits LSB first, an optional parity bit, then a stop bit.
// One CLK cycle is one bit period.
// Ports:
//   CLK   : bit-rate clock, all logic on its rising edge
//   RST   : synchronous reset, active-high
//   tx_if : slave side of uart_tx_ctrl_if (payload and strobe in, mux select,
//           serial bit, parity bit and busy out)
// All outputs come straight from flops.
module uart_tx_ctrl #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input logic           CLK,
  input logic           RST,
  uart_tx_ctrl_if.slave tx_if
);

  localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);

  // State encodings equal the mux_sel codes, so the state register drives the mux directly.
  typedef enum logic [2:0] {
    StStart  = 3'b000,
    StData   = 3'b001,
    StParity = 3'b010,
    StStop   = 3'b011,
    StIdle   = 3'b101
  } state_e;

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  ser_q;
  logic                  par_q;
  logic                  busy_q;

  logic                  accept;
  logic [CntW-1:0]       cnt_inc;

  // A new byte may start only when the line is idle or on the final stop bit.
  assign accept  = tx_if.Data_Valid && ((state_q == StIdle) || (state_q == StStop));
  assign cnt_inc = cnt_q + CntW'(1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      data_q   <= '0;
      par_en_q <= 1'b0;
      ser_q    <= 1'b0;
      par_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else if (accept) begin
      // PAR_TYP only matters for the parity value, so it is folded into par_q here
      // rather than kept in its own flop.
      data_q   <= tx_if.P_DATA;
      par_en_q <= tx_if.PAR_EN;
      par_q    <= (^tx_if.P_DATA) ^ tx_if.PAR_TYP;
      state_q  <= StStart;
      cnt_q    <= '0;
      ser_q    <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          ser_q  <= 1'b0;
          busy_q <= 1'b0;
        end
        StStart: begin
          // ser_q is registered, so the bit shown in the first DATA cycle is loaded here.
          state_q <= StData;
          cnt_q   <= '0;
          ser_q   <= data_q[0];
        end
        StData: begin
          if (cnt_q == LastCnt) begin
            cnt_q   <= '0;
            ser_q   <= 1'b0;
            state_q <= par_en_q ? StParity : StStop;
          end else begin
            cnt_q <= cnt_inc;
            ser_q <= data_q[cnt_inc];
          end
        end
        StParity: begin
          state_q <= StStop;
          ser_q   <= 1'b0;
        end
        StStop: begin
          state_q <= StIdle;
          ser_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
          ser_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_if.mux_sel  = state_q;
  assign tx_if.ser_data = ser_q;
  assign tx_if.par_bit  = par_q;
  assign tx_if.busy     = busy_q;

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Upstream control and serialiser stage of the UART transmitter. It accepts a parallel byte with a valid strobe and sequences the frame: start, data bits LSB first, optional parity, then stop. It drives the frame-bit select, serial data bit and parity bit into the TX output multiplexer, and raises busy for the whole frame. One CLK cycle equals one bit period; CLK is the baud-rate clock.

Parameters:
DATA_WIDTH, 8, payload bits per frame (valid range 5..9)

Ports:
CLK  input  1  bit-rate clock; all logic on its rising edge
RST  input  1  synchronous reset, active-high
P_DATA  input  DATA_WIDTH  parallel byte to transmit
Data_Valid  input  1  P_DATA valid; sampled only when the block can accept
PAR_EN  input  1  1 = insert parity bit
PAR_TYP  input  1  0 = even parity, 1 = odd parity
mux_sel  output  3  frame-bit select to the TX mux: 000 start, 001 data, 010 parity, 011 stop, 101 idle
ser_data  output  1  current data bit
par_bit  output  1  parity bit of the latched byte
busy  output  1  frame in progress

Behaviour:
- All state and outputs are registered. RST is sampled on the CLK edge.
- Reset values: state IDLE, mux_sel=101, ser_data=0, par_bit=0, busy=0, bit counter=0, data latch=0.
- States and mux_sel encoding: IDLE (101), START (000), DATA (001), PARITY (010), STOP (011).
- Accept condition: Data_Valid=1 while the block is in IDLE or STOP.
  - On accept, latch P_DATA, PAR_EN and PAR_TYP.
  - In the same cycle, compute par_bit = ^P_DATA XOR PAR_TYP.
  - The next cycle is START.
- Data_Valid in START, DATA or PARITY is ignored. It is not queued and does not corrupt the latched frame.
- Transitions:
  - IDLE -> START on accept; otherwise stay in IDLE.
  - START -> DATA after 1 cycle.
  - DATA holds for exactly DATA_WIDTH cycles. Bit counter runs 0..DATA_WIDTH-1. On the last count, go to PARITY if the latched PAR_EN=1, else go to STOP.
  - PARITY -> STOP after 1 cycle.
  - STOP -> START if accept (back-to-back, no idle gap); else STOP -> IDLE.
- ser_data equals latched_data[bit_cnt] during DATA, so bit 0 comes first. It is 0 in every other state.
  - Bit counter resets to 0 on DATA exit.
  - Counter width is clog2(DATA_WIDTH) and it never wraps past DATA_WIDTH-1.
- par_bit holds its value from accept until the next accept. It is stable through the whole frame.
- busy=1 in START, DATA, PARITY and STOP; busy=0 in IDLE.
  - busy goes high one cycle after accept, aligned with mux_sel=000.
  - In back-to-back transfers, busy stays high continuously.
- Frame length is DATA_WIDTH+2 cycles, or DATA_WIDTH+3 with parity.
- Changes to PAR_EN or PAR_TYP mid-frame have no effect on the current frame.
- RST mid-frame:
  - Next cycle is IDLE, mux_sel=101 and busy=0.
  - The partial frame is abandoned, with no stop bit.
  - A Data_Valid in the same cycle as RST is dropped.
- The next Data_Valid after RST is accepted normally.

Test Plan:
1. Reset, then PAR_EN=0, P_DATA=0xA5, Data_Valid pulsed 1 cycle -> mux_sel sequence 000, then 001x8, then 011, then 101. ser_data over the DATA cycles = 1,0,1,0,0,1,0,1. busy high for exactly 10 cycles.
2. PAR_EN=1, PAR_TYP=0, P_DATA=0x07 -> frame length 11 cycles. par_bit=1 and mux_sel=010 in cycle 10. Repeat with PAR_TYP=1 -> par_bit=0.
3. P_DATA=0xA5 with PAR_TYP=0 -> par_bit=0. Toggle PAR_TYP and P_DATA during DATA -> par_bit and ser_data stay unchanged for that frame.
4. Back-to-back: Data_Valid asserted in the STOP cycle with P_DATA=0x3C -> next cycle mux_sel=000. busy never drops. Second frame ser_data = 0,0,1,1,1,1,0,0.
5. Data_Valid pulsed mid-DATA with P_DATA=0xFF -> ignored. Current frame completes unchanged and the block returns to IDLE (mux_sel=101) afterwards.
6. RST asserted during the 4th DATA cycle -> next cycle mux_sel=101, busy=0, ser_data=0. A subsequent 0x55 frame is transmitted correctly from START.
